kogge_adder_arbiter: RTL and testbench

Shares one combinational 32-bit Kogge-Stone adder between NREQ requesters. Round-robin grants a valid/ready request, registers the operands, drives the shared adder, and returns a tagged 32-bit sum and carry-out through a valid/ready response port. Two-stage pipeline, one add per cycle sustained. Sits between requesting datapath blocks and the single adder instance.

---
 rtl/kogge_arb_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/kogge_adder_arbiter.sv | 145 ++++++++++++++
 tb/tb_kogge_adder_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kogge_arb_pkg.sv
// Shared types and helpers for the Kogge-Stone adder arbiter slice.
// Beats carry a requester id sized for the largest supported NREQ (16).
package kogge_arb_pkg;

  localparam int ADD_W   = 32;
  localparam int MAX_REQ = 16;
  localparam int MAX_IDW = 4;

  typedef struct packed {
    logic [ADD_W-1:0]   a;
    logic [ADD_W-1:0]   b;
    logic               cin;
    logic [MAX_IDW-1:0] id;
    logic               last;
  } beat_t;

  // Round-robin pick: first valid index after ptr, wrapping modulo nreq.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [MAX_IDW-1:0] ptr,
                                                 input int                 nreq);
    logic [MAX_REQ-1:0] grant;
    logic [MAX_IDW-1:0] idx;
    logic               found;
    grant = '0;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = MAX_IDW'((int'(ptr) + i) % nreq);
      if (i <= nreq && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an optional lock that pins the grant to one
// requester; the priority pointer moves to the granted index on update.
module rr_arbiter
  import kogge_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] valid_i,
  input  logic            lock_i,
  input  logic [IDW-1:0]  lock_id_i,
  input  logic            update_i,
  output logic [NREQ-1:0] grant_o
);

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [MAX_REQ-1:0] validWide;
  logic [MAX_REQ-1:0] pickWide;

  always_comb begin
    validWide             = '0;
    validWide[NREQ-1:0]   = valid_i;
    pickWide              = rr_pick(validWide, MAX_IDW'(ptr_q), NREQ);
    grant_o               = pickWide[NREQ-1:0];
    if (lock_i) begin
      grant_o             = '0;
      grant_o[lock_id_i]  = valid_i[lock_id_i];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update_i) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_o[i]) ptr_d = IDW'(i);
      end
    end
  end

  // Reset to the last index so requester 0 is searched first.
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= IDW'(NREQ - 1);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/kogge_adder_arbiter.sv
// Shares one external Kogge-Stone adder between NREQ requesters through an
// operand stage (S1) and a result stage (S2). Chained adds: KSA_ARB_CHAIN_EN.
module kogge_adder_arbiter
  import kogge_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*ADD_W-1:0] req_a_i,
  input  logic [NREQ*ADD_W-1:0] req_b_i,
  input  logic [NREQ-1:0]       req_cin_i,
`ifdef KSA_ARB_CHAIN_EN
  input  logic [NREQ-1:0]       req_last_i,
  output logic                  rsp_last_o,
`endif
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [IDW-1:0]        rsp_id_o,
  output logic [ADD_W-1:0]      rsp_sum_o,
  output logic                  rsp_cout_o,
  output logic [ADD_W-1:0]      add_a_o,
  output logic [ADD_W-1:0]      add_b_o,
  output logic                  add_cin_o,
  input  logic [ADD_W-1:0]      add_sum_i,
  input  logic                  add_cout_i
);

  beat_t            s1Beat_q, newBeat;
  logic             s1Valid_q;
  logic             rspValid_q, rspCout_q;
  logic [ADD_W-1:0] rspSum_q;
  logic [IDW-1:0]   rspId_q;
  logic [NREQ-1:0]  grant;
  logic             s2Load, s1CanLoad, fire;
  logic             lockActive;
  logic [IDW-1:0]   lockIdent;

  assign s2Load      = s1Valid_q & (~rspValid_q | rsp_ready_i);
  assign s1CanLoad   = ~s1Valid_q | s2Load;
  assign req_ready_o = grant & {NREQ{s1CanLoad}};
  assign fire        = |(req_ready_o & req_valid_i);

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) uArb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (req_valid_i),
    .lock_i    (lockActive),
    .lock_id_i (lockIdent),
    .update_i  (fire),
    .grant_o   (grant)
  );

  always_comb begin
    newBeat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        newBeat.a   = req_a_i[ADD_W*i +: ADD_W];
        newBeat.b   = req_b_i[ADD_W*i +: ADD_W];
        newBeat.cin = req_cin_i[i];
        newBeat.id  = MAX_IDW'(i);
`ifdef KSA_ARB_CHAIN_EN
        newBeat.last = req_last_i[i];
`else
        newBeat.last = 1'b1;
`endif
      end
    end
  end

  // S1 keeps its contents when it drains so add_* hold their last value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1Valid_q <= 1'b0;
      s1Beat_q  <= '0;
    end else if (fire) begin
      s1Valid_q <= 1'b1;
      s1Beat_q  <= newBeat;
    end else if (s2Load) begin
      s1Valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rspValid_q <= 1'b0;
      rspSum_q   <= '0;
      rspCout_q  <= 1'b0;
      rspId_q    <= '0;
    end else if (s2Load) begin
      rspValid_q <= 1'b1;
      rspSum_q   <= add_sum_i;
      rspCout_q  <= add_cout_i;
      rspId_q    <= IDW'(s1Beat_q.id);
    end else if (rsp_ready_i) begin
      rspValid_q <= 1'b0;
    end
  end

`ifdef KSA_ARB_CHAIN_EN
  logic           lock_q, s1Cont_q, chainCarry_q, rspLast_q;
  logic [IDW-1:0] lockId_q;

  // A last=0 fire pins the grant; continuation beats take the saved carry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q       <= 1'b0;
      lockId_q     <= '0;
      s1Cont_q     <= 1'b0;
      chainCarry_q <= 1'b0;
      rspLast_q    <= 1'b0;
    end else begin
      if (fire) begin
        s1Cont_q <= lock_q;
        lock_q   <= ~newBeat.last;
        lockId_q <= IDW'(newBeat.id);
      end
      if (s2Load) begin
        rspLast_q <= s1Beat_q.last;
        if (!s1Beat_q.last) chainCarry_q <= add_cout_i;
      end
    end
  end

  assign lockActive = lock_q;
  assign lockIdent  = lockId_q;
  assign add_cin_o  = s1Cont_q ? chainCarry_q : s1Beat_q.cin;
  assign rsp_last_o = rspLast_q;
`else
  assign lockActive = 1'b0;
  assign lockIdent  = '0;
  assign add_cin_o  = s1Beat_q.cin;
`endif

  assign add_a_o     = s1Beat_q.a;
  assign add_b_o     = s1Beat_q.b;
  assign rsp_valid_o = rspValid_q;
  assign rsp_sum_o   = rspSum_q;
  assign rsp_cout_o  = rspCout_q;
  assign rsp_id_o    = rspId_q;

endmodule

// File: tb/tb_kogge_adder_arbiter.sv
// Directed bench for kogge_adder_arbiter with a behavioural shared adder;
// chained-add vectors run only when KSA_ARB_CHAIN_EN is defined.
module tb_kogge_adder_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req_valid, req_ready, req_cin, req_last;
  logic [NREQ*32-1:0] req_a, req_b;
  logic             rsp_valid, rsp_ready, rsp_cout;
  logic [IDW-1:0]   rsp_id;
  logic [31:0]      rsp_sum, add_a, add_b, add_sum;
  logic             add_cin, add_cout;
`ifdef KSA_ARB_CHAIN_EN
  logic             rsp_last;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  // Stand-in for the external shared adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

  kogge_adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_cin_i   (req_cin),
`ifdef KSA_ARB_CHAIN_EN
    .req_last_i  (req_last),
    .rsp_last_o  (rsp_last),
`endif
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_sum_o   (rsp_sum),
    .rsp_cout_o  (rsp_cout),
    .add_a_o     (add_a),
    .add_b_o     (add_b),
    .add_cin_o   (add_cin),
    .add_sum_i   (add_sum),
    .add_cout_i  (add_cout)
  );

  // Operand table for the streaming tests, with hand-computed results.
  logic [31:0] rrA[4]    = '{32'h0000_0001, 32'h0000_0010, 32'h8000_0000, 32'hFFFF_FFF0};
  logic [31:0] rrB[4]    = '{32'h0000_0002, 32'h0000_0020, 32'h8000_0000, 32'h0000_0020};
  logic [31:0] rrSum[4]  = '{32'h0000_0003, 32'h0000_0030, 32'h0000_0000, 32'h0000_0010};
  logic        rrCout[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  // Backpressure schedule, one entry per cycle.
  logic [3:0] bpReady[9] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                             4'b0100, 4'b1000, 4'b0000, 4'b0000};
  logic       bpRspV[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  int         bpId[9]    = '{0, 0, 0, 0, 0, 0, 1, 2, 3};

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic last);
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
    req_cin[idx]        = cin;
    req_last[idx]       = last;
  endtask

  task automatic doReset();
    rst       = 1'b1;
    req_valid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic loadTable();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, rrA[i], rrB[i], 1'b0, 1'b1);
  endtask

  initial begin
    req_a = '0; req_b = '0; req_cin = '0; req_last = '1; rsp_ready = 1'b1;
    doReset();

    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_rsp_sum",   64'(rsp_sum),   64'd0);
    checkOutput("reset_rsp_cout",  64'(rsp_cout),  64'd0);
    checkOutput("reset_rsp_id",    64'(rsp_id),    64'd0);
    checkOutput("reset_add_a",     64'(add_a),     64'd0);
    checkOutput("reset_add_b",     64'(add_b),     64'd0);
    checkOutput("reset_add_cin",   64'(add_cin),   64'd0);
    checkOutput("reset_req_ready", 64'(req_ready), 64'd0);

    // Single add from requester 2 with full carry ripple.
    applyStimulus(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
    req_valid = 4'b0100;
    #1;
    checkOutput("single_ready", 64'(req_ready), 64'h4);
    step();
    req_valid = '0;
    checkOutput("single_add_a",   64'(add_a),     64'hFFFF_FFFF);
    checkOutput("single_add_b",   64'(add_b),     64'h1);
    checkOutput("single_t1_valid", 64'(rsp_valid), 64'd0);
    step();
    checkOutput("single_valid", 64'(rsp_valid), 64'd1);
    checkOutput("single_sum",   64'(rsp_sum),   64'h0);
    checkOutput("single_cout",  64'(rsp_cout),  64'd1);
    checkOutput("single_id",    64'(rsp_id),    64'd2);
    step();
    checkOutput("single_drain", 64'(rsp_valid), 64'd0);

    // Carry-in on requester 0; pointer sits at 2 so 0 is reached by wrap.
    applyStimulus(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1);
    req_valid = 4'b0001;
    #1;
    checkOutput("cin_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    step();
    checkOutput("cin_valid", 64'(rsp_valid), 64'd1);
    checkOutput("cin_sum",   64'(rsp_sum),   64'hFFFF_FFFF);
    checkOutput("cin_cout",  64'(rsp_cout),  64'd0);
    checkOutput("cin_id",    64'(rsp_id),    64'd0);
    step();

    // Round robin with all four requesters valid and no backpressure.
    doReset();
    loadTable();
    req_valid = 4'b1111;
    #1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      logic [3:0] expReady;
      int k;
      expReady = 4'b0001 << (cyc % 4);
      checkOutput($sformatf("rr_ready_c%0d", cyc), 64'(req_ready), 64'(expReady));
      if (cyc >= 2) begin
        k = (cyc - 2) % 4;
        checkOutput($sformatf("rr_valid_c%0d", cyc), 64'(rsp_valid), 64'd1);
        checkOutput($sformatf("rr_id_c%0d", cyc),    64'(rsp_id),    64'(k));
        checkOutput($sformatf("rr_sum_c%0d", cyc),   64'(rsp_sum),   64'(rrSum[k]));
        checkOutput($sformatf("rr_cout_c%0d", cyc),  64'(rsp_cout),  64'(rrCout[k]));
      end else begin
        checkOutput($sformatf("rr_valid_c%0d", cyc), 64'(rsp_valid), 64'd0);
      end
      step();
    end
    req_valid = '0;
    step(); step(); step();

    // Backpressure: rsp_ready low for five cycles while streaming.
    doReset();
    loadTable();
    for (int cyc = 0; cyc < 9; cyc++) begin
      req_valid = (cyc < 7) ? 4'b1111 : 4'b0000;
      rsp_ready = (cyc < 5) ? 1'b0 : 1'b1;
      #1;
      checkOutput($sformatf("bp_ready_c%0d", cyc), 64'(req_ready), 64'(bpReady[cyc]));
      checkOutput($sformatf("bp_valid_c%0d", cyc), 64'(rsp_valid), 64'(bpRspV[cyc]));
      if (bpRspV[cyc]) begin
        checkOutput($sformatf("bp_id_c%0d", cyc),  64'(rsp_id),  64'(bpId[cyc]));
        checkOutput($sformatf("bp_sum_c%0d", cyc), 64'(rsp_sum), 64'(rrSum[bpId[cyc]]));
      end
      step();
    end
    checkOutput("bp_drained", 64'(rsp_valid), 64'd0);

    // Reset with S1 and S2 both occupied.
    doReset();
    loadTable();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    step(); step();
    checkOutput("mid_s2_full", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    step();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checkOutput("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("mid_ptr_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    checkOutput("mid_no_stale", 64'(rsp_valid), 64'd0);
    step();
    checkOutput("mid_valid", 64'(rsp_valid), 64'd1);
    checkOutput("mid_id",    64'(rsp_id),    64'd0);
    checkOutput("mid_sum",   64'(rsp_sum),   64'h3);
    step();

`ifdef KSA_ARB_CHAIN_EN
    // 64-bit chained add from requester 1 while requester 3 waits.
    doReset();
    applyStimulus(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    applyStimulus(3, 32'h5, 32'h6, 1'b0, 1'b1);
    req_valid = 4'b1010;
    #1;
    checkOutput("chain_ready0", 64'(req_ready), 64'h2);
    step();
    applyStimulus(1, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("chain_lock_ready", 64'(req_ready), 64'h2);
    step();
    req_valid = 4'b1000;
    #1;
    checkOutput("chain_ready3", 64'(req_ready), 64'h8);
    checkOutput("chain_lo_sum",  64'(rsp_sum),  64'h0);
    checkOutput("chain_lo_cout", 64'(rsp_cout), 64'd1);
    checkOutput("chain_lo_last", 64'(rsp_last), 64'd0);
    checkOutput("chain_lo_id",   64'(rsp_id),   64'd1);
    step();
    req_valid = '0;
    checkOutput("chain_hi_sum",  64'(rsp_sum),  64'h1);
    checkOutput("chain_hi_last", 64'(rsp_last), 64'd1);
    checkOutput("chain_hi_id",   64'(rsp_id),   64'd1);
    step();
    checkOutput("chain_r3_id",  64'(rsp_id),  64'd3);
    checkOutput("chain_r3_sum", 64'(rsp_sum), 64'hB);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
